// File: rtl/counter.sv
// Parameterised synchronous up/down counter, wrapping modulo 2^CNT_WIDTH.
// Synchronous active-high reset; output is driven straight from the count register.
module counter #(
   parameter int unsigned CNT_WIDTH = 4
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 CounterOp,
   output logic [CNT_WIDTH-1:0] CounterOut
);

   logic [CNT_WIDTH-1:0] count_q;
   logic [CNT_WIDTH-1:0] count_d;

   // Width-exact add/subtract: carry and borrow fall off the top, giving silent wrap.
   always_comb begin
      count_d = count_q;
      if (CounterOp) begin
         count_d = count_q + CNT_WIDTH'(1);
      end else begin
         count_d = count_q - CNT_WIDTH'(1);
      end
   end

   // Despite its historical name, Reset_n is active-high.
   always_ff @(posedge Clk) begin
      if (Reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign CounterOut = count_q;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: three widths (1, 4, 8) share one stimulus stream;
// a signed step-count model gives expected values via modular reduction.
module tb_counter;

   logic       Clk;
   logic       Reset_n;
   logic       CounterOp;
   logic [3:0] out4;
   logic [0:0] out1;
   logic [7:0] out8;

   int checks;
   int errors;

   typedef struct {
      int    e4;
      int    e1;
      int    e8;
      string tag;
   } exp_t;

   exp_t sb_q[$];
   int   model;
   bit   model_valid;

   counter #(.CNT_WIDTH(4)) u_w4 (
      .Clk(Clk), .Reset_n(Reset_n), .CounterOp(CounterOp), .CounterOut(out4)
   );
   counter #(.CNT_WIDTH(1)) u_w1 (
      .Clk(Clk), .Reset_n(Reset_n), .CounterOp(CounterOp), .CounterOut(out1)
   );
   counter #(.CNT_WIDTH(8)) u_w8 (
      .Clk(Clk), .Reset_n(Reset_n), .CounterOp(CounterOp), .CounterOut(out8)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic int wrap(input int m, input int w);
      int modulus;
      modulus = 1 << w;
      return ((m % modulus) + modulus) % modulus;
   endfunction

   // One clock edge: drive inputs, optionally glitch reset mid-low-phase, record expectation.
   task automatic step(input bit rst, input bit op, input string tag, input bit glitch = 1'b0);
      exp_t e;
      @(negedge Clk);
      Reset_n   = rst;
      CounterOp = op;
      if (glitch) begin
         #1 Reset_n = 1'b1;
         #1 Reset_n = 1'b0;
      end
      @(posedge Clk);
      if (rst) begin
         model       = 0;
         model_valid = 1'b1;
      end else if (op) begin
         model = model + 1;
      end else begin
         model = model - 1;
      end
      if (model_valid) begin
         e.e4  = wrap(model, 4);
         e.e1  = wrap(model, 1);
         e.e8  = wrap(model, 8);
         e.tag = tag;
         sb_q.push_back(e);
      end
   endtask

   task automatic cmp(input string tag, input string w, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s %s got %0d expected %0d", tag, w, got, exp);
      end
   endtask

   // Monitor: the count is always presented, so one expectation is retired per falling edge.
   always @(negedge Clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         cmp(e.tag, "w4", int'(out4), e.e4);
         cmp(e.tag, "w1", int'(out1), e.e1);
         cmp(e.tag, "w8", int'(out8), e.e8);
      end
   end

   initial begin
      int drain;
      checks      = 0;
      errors      = 0;
      model       = 0;
      model_valid = 1'b0;
      Reset_n     = 1'b0;
      CounterOp   = 1'b1;

      // Reset then count up 0..5
      step(1'b1, 1'b1, "reset");
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "up5");

      // Up wrap: 17 edges after reset covers 15 -> 0 -> 1 at width 4
      step(1'b1, 1'b1, "reset");
      for (int i = 0; i < 17; i++) step(1'b0, 1'b1, "upwrap");

      // Width-8 wrap 255 -> 0
      step(1'b1, 1'b0, "reset");
      for (int i = 0; i < 260; i++) step(1'b0, 1'b1, "upwrap8");

      // Down wrap
      step(1'b1, 1'b1, "reset");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "downwrap");

      // Direction change at 6
      step(1'b1, 1'b1, "reset");
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, "dir_up");
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, "dir_down");

      // Mid-count reset held 2 edges with CounterOp = 1
      step(1'b1, 1'b0, "reset");
      for (int i = 0; i < 9; i++) step(1'b0, 1'b1, "mid_up");
      step(1'b1, 1'b1, "mid_rst");
      step(1'b1, 1'b1, "mid_rst");
      step(1'b0, 1'b1, "mid_after");

      // Short reset pulse between edges must be ignored
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "glitch", 1'b1);

      // Randomised traffic with occasional reset
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), "random");
      end

      drain = 0;
      while (sb_q.size() > 0 && drain < 5) begin
         @(posedge Clk);
         drain++;
      end
      if (sb_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending %0d expected 0", sb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
